rv32m_mul_issue_ctrl: RTL

Issue/sequencing controller between the core's RV32M decode stage and the unsigned 32x32 multiplier datapath and its control FSM. It accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and converts signed operands to magnitudes. It restarts and runs the multiplier, applies sign correction and returns the selected 32-bit half with a tag. A one-entry product cache serves the MULH[S][U]-then-MUL fused sequence without re-running the datapath.

---
 rtl/rv32m_mul_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32m_mul_issue_ctrl.sv
// RV32M multiply issue/sequencing controller: accepts MUL/MULH/MULHSU/MULHU,
// feeds operand magnitudes to an unsigned multiplier, sign-fixes the product
// and returns the selected half. A one-entry product cache serves fused
// MULH[S][U] -> MUL pairs without re-running the datapath.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o request handshake
//   req_funct3_i            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx illegal
//   req_rs1_i, req_rs2_i    operands A and B
//   req_tag_i               destination tag, returned on rsp_tag_o
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_data_o, rsp_tag_o   result and its tag
//   rsp_err_o               illegal funct3 or datapath timeout (data forced 0)
//   dp_clear_o              one-cycle datapath control reset pulse
//   dp_mult_en_o            multiplier enable, high while running
//   dp_op_a_o, dp_op_b_o    registered operand magnitudes
//   dp_done_i, dp_product_i datapath completion and unsigned 64-bit product

module rv32m_mul_issue_ctrl #(
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 16,
    parameter int FUSE_EN     = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_rs1_i,
    input  logic [31:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             dp_clear_o,
    output logic             dp_mult_en_o,
    output logic [31:0]      dp_op_a_o,
    output logic [31:0]      dp_op_b_o,
    input  logic             dp_done_i,
    input  logic [63:0]      dp_product_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FIX,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;

    // Latched request
    logic [2:0]       f3_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q;
    logic             hit_q;

    // Datapath side
    logic [31:0]      opa_q;
    logic [31:0]      opb_q;
    logic [63:0]      prod_q;

    // Product cache
    logic             c_vld_q;
    logic [31:0]      c_rs1_q;
    logic [31:0]      c_rs2_q;
    logic [2:0]       c_f3_q;
    logic [63:0]      c_prod_q;

    // Response registers
    logic [31:0]      rsp_data_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_err_q;

    // FSM strobes
    logic acc;
    logic hit;
    logic ld_ill;
    logic ld_hit;
    logic ld_miss;
    logic cap;
    logic fix;
    logic tmo;

    // Operand decode
    logic        sgn_a;
    logic        sgn_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] fix_prod;

    assign acc = req_valid_i & ready_q;

    always_comb begin
        sgn_a = ((req_funct3_i == F3_MULH) || (req_funct3_i == F3_MULHSU))
                && req_rs1_i[31];
        sgn_b = (req_funct3_i == F3_MULH) && req_rs2_i[31];
        // Negating 0x80000000 yields 0x80000000, which is the correct
        // unsigned magnitude, so no overflow handling is needed.
        mag_a = sgn_a ? (~req_rs1_i + 32'd1) : req_rs1_i;
        mag_b = sgn_b ? (~req_rs2_i + 32'd1) : req_rs2_i;
    end

    // A MUL may hit an entry of any signedness: the low 32 bits of the
    // product do not depend on operand signedness.
    assign hit = (FUSE_EN != 0) && c_vld_q
                 && (req_rs1_i == c_rs1_q)
                 && (req_rs2_i == c_rs2_q)
                 && ((req_funct3_i == F3_MUL) || (req_funct3_i == c_f3_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ld_ill  = 1'b0;
        ld_hit  = 1'b0;
        ld_miss = 1'b0;
        cap     = 1'b0;
        fix     = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (req_funct3_i[2]) begin
                        state_d = S_RESP;
                        ld_ill  = 1'b1;
                    end else if (hit) begin
                        state_d = S_FIX;
                        ld_hit  = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        ld_miss = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (dp_done_i) begin
                    state_d = S_FIX;
                    cap     = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    tmo     = 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_RESP;
                fix     = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f3_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            tag_q <= '0;
            neg_q <= 1'b0;
            hit_q <= 1'b0;
        end else if (acc) begin
            f3_q  <= req_funct3_i;
            rs1_q <= req_rs1_i;
            rs2_q <= req_rs2_i;
            tag_q <= req_tag_i;
            neg_q <= sgn_a ^ sgn_b;
            hit_q <= ld_hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            opa_q  <= '0;
            opb_q  <= '0;
            prod_q <= '0;
        end else begin
            if (ld_miss) begin
                opa_q <= mag_a;
                opb_q <= mag_b;
            end
            if (cap) begin
                prod_q <= dp_product_i;
            end
        end
    end

    // Signed result from the magnitude product, or the cached signed product
    // on a hit.
    always_comb begin
        if (hit_q) begin
            fix_prod = c_prod_q;
        end else if (neg_q) begin
            fix_prod = ~prod_q + 64'd1;
        end else begin
            fix_prod = prod_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            c_vld_q  <= 1'b0;
            c_rs1_q  <= '0;
            c_rs2_q  <= '0;
            c_f3_q   <= '0;
            c_prod_q <= '0;
        end else if (tmo) begin
            c_vld_q <= 1'b0;
        end else if (fix && !hit_q) begin
            c_vld_q  <= (FUSE_EN != 0);
            c_rs1_q  <= rs1_q;
            c_rs2_q  <= rs2_q;
            c_f3_q   <= f3_q;
            c_prod_q <= fix_prod;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else if (ld_ill) begin
            rsp_data_q <= '0;
            rsp_tag_q  <= req_tag_i;
            rsp_err_q  <= 1'b1;
        end else if (tmo) begin
            rsp_data_q <= '0;
            rsp_tag_q  <= tag_q;
            rsp_err_q  <= 1'b1;
        end else if (fix) begin
            rsp_data_q <= (f3_q == F3_MUL) ? fix_prod[31:0]
                                           : fix_prod[63:32];
            rsp_tag_q  <= tag_q;
            rsp_err_q  <= 1'b0;
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_data_o   = rsp_data_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_err_o    = rsp_err_q;
    assign dp_clear_o   = (state_q == S_CLEAR);
    assign dp_mult_en_o = (state_q == S_RUN);
    assign dp_op_a_o    = opa_q;
    assign dp_op_b_o    = opb_q;

endmodule
